spi_rdid_responder: RTL and testbench



---
 rtl/spi_flash_pkg.sv | 25 ++
 rtl/spi_rdid_responder_if.sv | 23 ++
 rtl/spi_pin_sync.sv | 64 ++++++
 rtl/spi_rdid_responder.sv | 183 ++++++++++++++++++
 tb/tb_spi_rdid_responder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_flash_pkg.sv
// Shared constants and types for the SPI flash-side responders.
// Opcodes, default JEDEC ID bytes and the responder state encoding.
package spi_flash_pkg;

  localparam logic [7:0] OP_RDID      = 8'h9F;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] DEF_MANUF_ID = 8'h20;
  localparam logic [7:0] DEF_MEM_TYPE = 8'h20;
  localparam logic [7:0] DEF_MEM_CAP  = 8'h15;
  localparam logic [4:0] RESP_BITS    = 5'd24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CMD    = 2'd1,
    RESP   = 2'd2,
    IGNORE = 2'd3
  } spi_state_e;

  function automatic logic [23:0] jedec_word(input logic [7:0] manuf,
                                             input logic [7:0] mtype,
                                             input logic [7:0] cap);
    return {manuf, mtype, cap};
  endfunction

endpackage

// File: rtl/spi_rdid_responder_if.sv
// Serial pins plus status outputs of the RDID responder.
// The master side drives the SPI pins; the slave side answers them.
interface spi_rdid_responder_if;
  logic       spi_clk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] cmd_byte;
  logic       cmd_strobe;
  logic       rdid_done;
  logic       busy;

  modport master (
    output spi_clk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe, cmd_byte, cmd_strobe, rdid_done, busy
  );

  modport slave (
    input  spi_clk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe, cmd_byte, cmd_strobe, rdid_done, busy
  );
endinterface

// File: rtl/spi_pin_sync.sv
// Synchronizes the SPI pins into the CCLK domain and produces registered
// edge pulses; pin-to-pulse latency is STAGES+1 CCLK.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic mosi,
  output logic cs_n_lvl,
  output logic mosi_lvl,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);

  logic [STAGES-1:0] sclk_sync_r;
  logic [STAGES-1:0] cs_sync_r;
  logic [STAGES-1:0] mosi_sync_r;
  logic              sclk_hist_r;
  logic              cs_hist_r;
  logic              mosi_r;
  logic              sclk_rise_r;
  logic              sclk_fall_r;
  logic              cs_fall_r;
  logic              cs_rise_r;

  // Sync chains reset low so a chip select held low through reset yields no falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_r <= {STAGES{1'b0}};
      cs_sync_r   <= {STAGES{1'b0}};
      mosi_sync_r <= {STAGES{1'b0}};
      sclk_hist_r <= 1'b0;
      cs_hist_r   <= 1'b0;
      mosi_r      <= 1'b0;
      sclk_rise_r <= 1'b0;
      sclk_fall_r <= 1'b0;
      cs_fall_r   <= 1'b0;
      cs_rise_r   <= 1'b0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[STAGES-2:0], sclk};
      cs_sync_r   <= {cs_sync_r[STAGES-2:0], cs_n};
      mosi_sync_r <= {mosi_sync_r[STAGES-2:0], mosi};
      sclk_hist_r <= sclk_sync_r[STAGES-1];
      cs_hist_r   <= cs_sync_r[STAGES-1];
      mosi_r      <= mosi_sync_r[STAGES-1];
      sclk_rise_r <= sclk_sync_r[STAGES-1] & ~sclk_hist_r;
      sclk_fall_r <= ~sclk_sync_r[STAGES-1] & sclk_hist_r;
      cs_rise_r   <= cs_sync_r[STAGES-1] & ~cs_hist_r;
      cs_fall_r   <= ~cs_sync_r[STAGES-1] & cs_hist_r;
    end
  end

  assign cs_n_lvl  = cs_hist_r;
  assign mosi_lvl  = mosi_r;
  assign sclk_rise = sclk_rise_r;
  assign sclk_fall = sclk_fall_r;
  assign cs_fall   = cs_fall_r;
  assign cs_rise   = cs_rise_r;

endmodule

// File: rtl/spi_rdid_responder.sv
// Flash-side SPI responder: decodes the command byte and answers RDID
// with the 3-byte JEDEC ID, MSB-first, driven on falling spi_clk edges.
module spi_rdid_responder
  import spi_flash_pkg::*;
#(
  parameter logic [7:0] RDID_OPCODE = OP_RDID,
  parameter logic [7:0] MANUF_ID    = DEF_MANUF_ID,
  parameter logic [7:0] MEM_TYPE    = DEF_MEM_TYPE,
  parameter logic [7:0] MEM_CAP     = DEF_MEM_CAP,
  parameter int         SYNC_STAGES = 2
) (
  input logic                 CCLK,
  input logic                 reset_n,
  spi_rdid_responder_if.slave bus
);

  logic       cs_n_s, mosi_s, sclk_rise_s, sclk_fall_s, cs_fall_s, cs_rise_s;
  spi_state_e state_r, state_nxt_s;
  logic [6:0] cmd_sh_r, cmd_sh_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [23:0] resp_sh_r, resp_sh_nxt_s;
  logic [4:0] resp_cnt_r, resp_cnt_nxt_s;
  logic       miso_r, miso_nxt_s, oe_r, oe_nxt_s;
  logic [7:0] cmd_byte_r, cmd_byte_nxt_s;
  logic       strobe_r, strobe_nxt_s, done_r, done_nxt_s, busy_r, busy_nxt_s;
  logic [7:0] rx_byte_s;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk       (CCLK),
    .rst_n     (reset_n),
    .sclk      (bus.spi_clk),
    .cs_n      (bus.spi_cs_n),
    .mosi      (bus.spi_mosi),
    .cs_n_lvl  (cs_n_s),
    .mosi_lvl  (mosi_s),
    .sclk_rise (sclk_rise_s),
    .sclk_fall (sclk_fall_s),
    .cs_fall   (cs_fall_s),
    .cs_rise   (cs_rise_s)
  );

  assign rx_byte_s = {cmd_sh_r, mosi_s};

  // State register
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state; a chip-select rise overrides any clock edge in the same cycle
  always_comb begin
    state_nxt_s = state_r;
    if (cs_rise_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs_fall_s && !cs_n_s) state_nxt_s = CMD;
          else                      state_nxt_s = IDLE;
        end
        CMD: begin
          if (sclk_rise_s && bit_cnt_r == 3'd7)
            state_nxt_s = (rx_byte_s == RDID_OPCODE) ? RESP : IGNORE;
          else
            state_nxt_s = CMD;
        end
        RESP:    state_nxt_s = RESP;
        IGNORE:  state_nxt_s = IGNORE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Next values of the datapath and of the registered outputs
  always_comb begin
    cmd_sh_nxt_s   = cmd_sh_r;
    bit_cnt_nxt_s  = bit_cnt_r;
    resp_sh_nxt_s  = resp_sh_r;
    resp_cnt_nxt_s = resp_cnt_r;
    miso_nxt_s     = miso_r;
    oe_nxt_s       = oe_r;
    cmd_byte_nxt_s = cmd_byte_r;
    strobe_nxt_s   = 1'b0;
    done_nxt_s     = 1'b0;
    busy_nxt_s     = (state_nxt_s != IDLE);
    if (cs_rise_s) begin
      oe_nxt_s       = 1'b0;
      miso_nxt_s     = 1'b0;
      bit_cnt_nxt_s  = 3'd0;
      resp_cnt_nxt_s = 5'd0;
    end else begin
      case (state_r)
        IDLE: begin
          oe_nxt_s       = 1'b0;
          miso_nxt_s     = 1'b0;
          bit_cnt_nxt_s  = 3'd0;
          resp_cnt_nxt_s = 5'd0;
        end
        CMD: begin
          if (sclk_rise_s) begin
            cmd_sh_nxt_s  = rx_byte_s[6:0];
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              cmd_byte_nxt_s = rx_byte_s;
              strobe_nxt_s   = 1'b1;
              resp_sh_nxt_s  = jedec_word(MANUF_ID, MEM_TYPE, MEM_CAP);
              resp_cnt_nxt_s = 5'd0;
            end else begin
              resp_cnt_nxt_s = resp_cnt_r;
            end
          end else begin
            cmd_sh_nxt_s = cmd_sh_r;
          end
        end
        RESP: begin
          // First fall presents bit 23 unshifted; later falls shift zeros in behind the ID
          if (sclk_fall_s) begin
            oe_nxt_s = 1'b1;
            if (resp_cnt_r == 5'd0) begin
              miso_nxt_s = resp_sh_r[23];
            end else begin
              resp_sh_nxt_s = {resp_sh_r[22:0], 1'b0};
              miso_nxt_s    = resp_sh_r[22];
            end
            if (resp_cnt_r < RESP_BITS) resp_cnt_nxt_s = resp_cnt_r + 5'd1;
            else                        resp_cnt_nxt_s = resp_cnt_r;
          end else if (sclk_rise_s && resp_cnt_r == RESP_BITS) begin
            done_nxt_s     = 1'b1;
            resp_cnt_nxt_s = RESP_BITS + 5'd1;
          end else begin
            done_nxt_s = 1'b0;
          end
        end
        IGNORE: begin
          oe_nxt_s   = 1'b0;
          miso_nxt_s = 1'b0;
        end
        default: begin
          oe_nxt_s   = 1'b0;
          miso_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge CCLK or negedge reset_n) begin
    if (!reset_n) begin
      cmd_sh_r   <= 7'd0;
      bit_cnt_r  <= 3'd0;
      resp_sh_r  <= 24'd0;
      resp_cnt_r <= 5'd0;
      miso_r     <= 1'b0;
      oe_r       <= 1'b0;
      cmd_byte_r <= 8'h00;
      strobe_r   <= 1'b0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      cmd_sh_r   <= cmd_sh_nxt_s;
      bit_cnt_r  <= bit_cnt_nxt_s;
      resp_sh_r  <= resp_sh_nxt_s;
      resp_cnt_r <= resp_cnt_nxt_s;
      miso_r     <= miso_nxt_s;
      oe_r       <= oe_nxt_s;
      cmd_byte_r <= cmd_byte_nxt_s;
      strobe_r   <= strobe_nxt_s;
      done_r     <= done_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign bus.spi_miso    = miso_r;
  assign bus.spi_miso_oe = oe_r;
  assign bus.cmd_byte    = cmd_byte_r;
  assign bus.cmd_strobe  = strobe_r;
  assign bus.rdid_done   = done_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_spi_rdid_responder.sv
// Bench for spi_rdid_responder: an SPI master at CCLK/8 plus a transaction-level
// model of the expected ID bytes, pulse counts, busy and output-enable rules.
module tb_spi_rdid_responder;

  logic CCLK = 1'b0;
  logic reset_n;
  spi_rdid_responder_if bus();

  spi_rdid_responder dut (
    .CCLK    (CCLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 CCLK = ~CCLK;

  int         n_cmp = 0;
  int         n_fail = 0;
  int         act_strobes = 0, act_dones = 0, exp_strobes = 0, exp_dones = 0;
  logic [7:0] exp_cmd = 8'h00;
  bit         oe_allowed = 1'b0;
  bit         armed = 1'b0;
  bit         seen_high = 1'b0;
  logic       cs_prev = 1'b1;
  int         settle = 0;
  logic [7:0] rx_bytes [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte k seen by the master: the JEDEC ID for RDID, zeros beyond it or for anything else
  function automatic logic [7:0] model_byte(input logic [7:0] op, input int k);
    if (op != 8'h9F) return 8'h00;
    case (k)
      0:       return 8'h20;
      1:       return 8'h20;
      2:       return 8'h15;
      default: return 8'h00;
    endcase
  endfunction

  // Per-cycle compare against the model, sampled just after the CCLK rising edge
  initial begin
    forever begin
      @(posedge CCLK);
      #1;
      if (!reset_n) begin
        seen_high = 1'b0;
        armed     = 1'b0;
        settle    = 0;
        check("rst_oe", bus.spi_miso_oe, 0);
        check("rst_miso", bus.spi_miso, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_strobe", bus.cmd_strobe, 0);
        check("rst_done", bus.rdid_done, 0);
        check("rst_cmd_byte", bus.cmd_byte, 0);
      end else begin
        if (bus.spi_cs_n !== cs_prev) settle = 0;
        else                          settle++;
        if (bus.spi_cs_n) begin
          seen_high = 1'b1;
          armed     = 1'b0;
        end else if (cs_prev && seen_high) begin
          armed = 1'b1;
        end
        if (bus.cmd_strobe) begin
          act_strobes++;
          check("strobe_cmd_byte", bus.cmd_byte, exp_cmd);
        end
        if (bus.rdid_done) act_dones++;
        if (settle >= 5) begin
          check("busy", bus.busy, (!bus.spi_cs_n && armed));
          if (bus.spi_cs_n) check("idle_cmd_byte", bus.cmd_byte, exp_cmd);
        end
        if (!oe_allowed && !(bus.spi_cs_n && settle < 5)) begin
          check("oe_quiet", bus.spi_miso_oe, 0);
          check("miso_quiet", bus.spi_miso, 0);
        end
      end
      cs_prev = bus.spi_cs_n;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic half_period();
    repeat (4) @(negedge CCLK);
  endtask

  task automatic shift_bit(input logic b);
    bus.spi_clk  = 1'b0;
    bus.spi_mosi = b;
    half_period();
    bus.spi_clk = 1'b1;
    half_period();
  endtask

  task automatic resp_bit(output logic b);
    bus.spi_clk = 1'b0;
    half_period();
    b = bus.spi_miso;
    if (oe_allowed) check("resp_oe", bus.spi_miso_oe, 1);
    bus.spi_clk = 1'b1;
    half_period();
  endtask

  task automatic cs_low(input bit mode3);
    bus.spi_clk  = mode3;
    bus.spi_cs_n = 1'b0;
    half_period();
  endtask

  task automatic cs_high(input bit mode3, input int gap);
    if (!mode3) begin
      bus.spi_clk = 1'b0;
      half_period();
    end
    bus.spi_cs_n = 1'b1;
    oe_allowed   = 1'b0;
    repeat (gap) @(negedge CCLK);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge CCLK);
    reset_n    = 1'b0;
    oe_allowed = 1'b0;
    exp_cmd    = 8'h00;
    #1;
    check("rst_now_oe", bus.spi_miso_oe, 0);
    check("rst_now_busy", bus.busy, 0);
    repeat (cycles) @(negedge CCLK);
    reset_n = 1'b1;
  endtask

  task automatic txn(input bit mode3, input logic [7:0] op, input int ncmd,
                     input int nresp, input int gap);
    logic b;
    bit   full;
    cs_low(mode3);
    full = (ncmd == 8) && armed;
    if (full) begin
      exp_cmd = op;
      exp_strobes++;
    end
    for (int i = 0; i < ncmd; i++) shift_bit(op[7-i]);
    if (full && op == 8'h9F) oe_allowed = 1'b1;
    for (int i = 0; i < nresp; i++) begin
      resp_bit(b);
      rx_bytes[i/8] = {rx_bytes[i/8][6:0], b};
    end
    if (full && op == 8'h9F && nresp >= 24) exp_dones++;
    if (full)
      for (int k = 0; k < nresp / 8; k++)
        check($sformatf("rx_byte%0d", k), rx_bytes[k], model_byte(op, k));
    cs_high(mode3, gap);
    check("strobe_count", act_strobes, exp_strobes);
    check("done_count", act_dones, exp_dones);
  endtask

  initial begin
    logic b;
    int   dones_before;
    reset_n      = 1'b0;
    bus.spi_clk  = 1'b0;
    bus.spi_cs_n = 1'b1;
    bus.spi_mosi = 1'b0;
    repeat (3) @(negedge CCLK);
    reset_n = 1'b1;
    repeat (6) @(negedge CCLK);

    // Mode 0 RDID
    txn(1'b0, 8'h9F, 8, 24, 8);
    check("t1_manuf", rx_bytes[0], 8'h20);
    check("t1_type", rx_bytes[1], 8'h20);
    check("t1_cap", rx_bytes[2], 8'h15);
    check("t1_cmd_byte", bus.cmd_byte, 8'h9F);
    check("t1_dones", act_dones, 1);

    // READ opcode is decoded but never answered
    txn(1'b0, 8'h03, 8, 24, 8);
    check("t2_cmd_byte", bus.cmd_byte, 8'h03);
    check("t2_dones", act_dones, 1);

    // Partial command after reset, then a full RDID
    do_reset(3);
    repeat (6) @(negedge CCLK);
    txn(1'b0, 8'h9F, 5, 0, 8);
    check("t3_cmd_kept", bus.cmd_byte, 8'h00);
    txn(1'b0, 8'h9F, 8, 24, 8);
    check("t3_cap", rx_bytes[2], 8'h15);

    // Five response bytes: trailing bytes are zero, single done pulse
    dones_before = act_dones;
    txn(1'b0, 8'h9F, 8, 40, 8);
    check("t4_byte3", rx_bytes[3], 8'h00);
    check("t4_byte4", rx_bytes[4], 8'h00);
    check("t4_one_done", act_dones - dones_before, 1);

    // Reset after 10 response bits with cs_n held low through release
    cs_low(1'b0);
    exp_cmd = 8'h9F;
    exp_strobes++;
    for (int i = 0; i < 8; i++) shift_bit(exp_cmd[7-i]);
    oe_allowed = 1'b1;
    for (int i = 0; i < 10; i++) resp_bit(b);
    do_reset(3);
    repeat (2) @(negedge CCLK);
    for (int i = 0; i < 8; i++) shift_bit(i != 1 && i != 2);
    check("t5_busy_low", bus.busy, 0);
    check("t5_cmd_byte", bus.cmd_byte, 8'h00);
    cs_high(1'b0, 8);
    check("t5_strobes", act_strobes, exp_strobes);
    txn(1'b0, 8'h9F, 8, 24, 8);
    check("t5_manuf", rx_bytes[0], 8'h20);
    check("t5_cap", rx_bytes[2], 8'h15);

    // Mode 3, back to back with a 4-CCLK chip-select gap
    bus.spi_clk = 1'b1;
    repeat (8) @(negedge CCLK);
    dones_before = act_dones;
    txn(1'b1, 8'h9F, 8, 24, 4);
    check("t6a_cap", rx_bytes[2], 8'h15);
    check("t6a_type", rx_bytes[1], 8'h20);
    txn(1'b1, 8'h9F, 8, 24, 8);
    check("t6b_cap", rx_bytes[2], 8'h15);
    check("t6b_manuf", rx_bytes[0], 8'h20);
    check("t6_two_dones", act_dones - dones_before, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
